priv_trap_ctrl: RTL and testbench
=================================

# priv_trap_ctrl

Sequential privilege-mode and trap sequencer for the RV64 core, successor to the combinational trap/priv logic in the instruction decoder. Holds the current privilege level (U/S/M). Accepts commit-stage trap events (ecall, illegal instruction, sret, mret) and external interrupts. For each accepted event it performs the required CSR updates one per cycle through a single CSR write port, then issues a PC redirect. Sits between the decoder/commit stage and the CSR file; flushes and stalls the pipeline while busy.

## Interface
- XLEN, 64, datapath width
- NUM_IRQ, 4, interrupt lines; line i uses interrupt cause code i
- HAS_UMODE, 1, 0 removes U-mode (MRET then returns to S)

- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- ex_valid  in  1  commit-stage instruction valid
- ex_event  in  3  0 none, 1 ecall, 2 illegal, 3 sret, 4 mret
- ex_pc  in  XLEN  pc of committing instruction
- ex_tval  in  XLEN  trap value (instruction bits for illegal, else 0)
- irq  in  NUM_IRQ  level interrupt requests
- mie  in  NUM_IRQ  per-line enables
- mstatus  in  XLEN  current mstatus (sstatus is its restricted view)
- medeleg  in  XLEN  exception delegation mask
- mtvec, stvec, mepc, sepc  in  XLEN  current CSR values
- csr_we  out  1  CSR write strobe
- csr_waddr  out  12  CSR address
- csr_wdata  out  XLEN  CSR write data
- flush  out  1  kill younger instructions, one cycle
- busy  out  1  stall commit
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  XLEN  redirect target
- priv  out  2  current privilege level (0 U, 1 S, 3 M)

## Operation
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, REDIR.
- Accept occurs in IDLE on an interrupt, or on ex_valid with ex_event≠0. On accept: latch pc, tval, mstatus, tvec, epc and target; pulse flush; go busy.
- Interrupt: selected when some irq[i]&mie[i] and (priv≠M or mstatus[3]). Lowest index wins. Beats any simultaneous ex_event. cause = {1,…,i}. epc = ex_pc. tval = 0. Target is always M.
- Exception causes: ecall 8/9/11 for U/S/M; illegal 2.
- sret in U, or mret outside M, is converted to illegal (cause 2, tval = ex_tval).
- Exception target is S if medeleg[cause] and priv≠M, else M.
- Trap sequence: IDLE→W_EPC→W_CAUSE→W_TVAL→W_STATUS→REDIR→IDLE.
  - Target S writes 0x141, 0x142, 0x143, 0x100. Target M writes 0x341, 0x342, 0x343, 0x300.
  - Status update, S target: SPP[8] ← priv[0]; SPIE[5] ← SIE[1]; SIE ← 0.
  - Status update, M target: MPP[12:11] ← priv; MPIE[7] ← MIE[3]; MIE ← 0.
  - All other status bits are written back unchanged.
  - priv ← target in W_STATUS.
  - redirect_pc = {tvec[XLEN-1:2], 2'b00} (direct mode only).
- sret sequence: IDLE→W_STATUS→REDIR. Status: SIE ← SPIE, SPIE ← 1, SPP ← 0. priv ← {0, SPP}. redirect_pc = sepc.
- mret sequence: same path. Status: MIE ← MPIE, MPIE ← 1, MPP ← U (S if HAS_UMODE=0). priv ← MPP. redirect_pc = mepc.
- Width rules: cause is zero-extended to XLEN; the interrupt flag is bit XLEN-1.

## Timing
- Reset values: state IDLE, priv = M (2'b11). csr_we, flush, busy, redirect_valid are 0; csr_waddr, csr_wdata, redirect_pc are 0.
- Accept cycle A: flush = 1 and busy = 1, registered so both are visible in cycle A+1.
- Trap: CSR writes in A+1 … A+4, one per cycle, csr_we high. redirect_valid in A+5. busy drops in A+6.
- xRET: status write in A+1, redirect in A+2.
- While busy: ex_valid and irq are ignored; no second accept. First new accept is possible in the cycle after REDIR.
- Latched snapshot values are used throughout a sequence; CSR input changes mid-sequence have no effect.
- Async reset mid-sequence aborts immediately: no further writes or redirect, priv returns to M.

## Structure
- Package riscv_priv_pkg holds:
  - priv encodings
  - ex_event encoding
  - CSR addresses (0x100/141/142/143/300/341/342/343)
  - status bit indices
  - exception cause codes
  - the FSM state enum
- Sub-module trap_cause_sel (combinational): interrupt priority, illegal-xRET conversion, cause/target/delegation select.
- Top level holds the FSM, snapshot registers and priv register.

## Test plan
- Reset then ecall from M, pc 0x80000010, mtvec 0x80001003: writes 0x341=0x80000010, 0x342=11, 0x343=0, 0x300 with MPP=3, MIE=0; redirect 0x80001000 at A+5.
- priv=U, medeleg[8]=1, ecall, stvec 0x2000: writes 0x141/0x142=8/0x143/0x100 with SPP=0; priv→S; redirect 0x2000.
- priv=S, mstatus SPP=0, SPIE=1, sret, sepc 0x4000: single 0x100 write with SIE=1, SPP=0; priv→U; redirect 0x4000 at A+2.
- priv=S, mret, ex_tval 0x30200073: illegal trap to M, mcause=2, mtval=0x30200073.
- irq=4'b0110, mie=4'b1110, priv=U, same-cycle ecall: interrupt wins, mcause=(1<<63)|1; ecall dropped.
- Trap in flight, rstn low at A+2: no csr_we after reset, priv=M, no redirect_valid.

Source files
------------

// File: rtl/riscv_priv_pkg.sv
// Shared encodings for the privilege/trap sequencer: privilege levels, commit
// events, CSR addresses, mstatus bit positions, cause codes and FSM states.
package riscv_priv_pkg;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam logic [2:0] EV_NONE    = 3'd0;
    localparam logic [2:0] EV_ECALL   = 3'd1;
    localparam logic [2:0] EV_ILLEGAL = 3'd2;
    localparam logic [2:0] EV_SRET    = 3'd3;
    localparam logic [2:0] EV_MRET    = 3'd4;

    localparam logic [11:0] CSR_SSTATUS = 12'h100;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_STVAL   = 12'h143;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int SIE_BIT  = 1;
    localparam int MIE_BIT  = 3;
    localparam int SPIE_BIT = 5;
    localparam int MPIE_BIT = 7;
    localparam int SPP_BIT  = 8;
    localparam int MPP_LO   = 11;
    localparam int MPP_HI   = 12;

    localparam logic [5:0] CAUSE_ILLEGAL = 6'd2;
    localparam logic [5:0] CAUSE_ECALL_U = 6'd8;
    localparam logic [5:0] CAUSE_ECALL_S = 6'd9;
    localparam logic [5:0] CAUSE_ECALL_M = 6'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_EPC,
        ST_W_CAUSE,
        ST_W_TVAL,
        ST_W_STATUS,
        ST_REDIR
    } trap_state_e;

endpackage

// File: rtl/trap_cause_sel.sv
// Combinational event classification: interrupt priority, illegal-xRET
// conversion, cause/tval selection and delegation target.
module trap_cause_sel
    import riscv_priv_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int NUM_IRQ = 4
) (
    input  logic               ex_valid,
    input  logic [2:0]         ex_event,
    input  logic [XLEN-1:0]    ex_tval,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] mie,
    input  logic               mstatus_mie,
    input  logic [1:0]         priv,
    input  logic [XLEN-1:0]    medeleg,
    output logic               take,
    output logic               is_xret,
    output logic               is_mret,
    output logic [XLEN-1:0]    cause,
    output logic [XLEN-1:0]    tval,
    output logic [1:0]         target
);

    logic [NUM_IRQ-1:0] pending;
    logic               irq_take;
    logic [XLEN-1:0]    irq_cause;
    logic               exc_take;
    logic [5:0]         exc_code;
    logic [XLEN-1:0]    exc_tval;
    logic               xret;
    logic               mret_sel;

    // Walk from the top so the lowest pending line is the last assignment.
    always_comb begin
        pending   = irq & mie;
        irq_take  = (|pending) && ((priv != PRIV_M) || mstatus_mie);
        irq_cause = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) irq_cause = XLEN'(i);
        end
        irq_cause[XLEN-1] = 1'b1;
    end

    always_comb begin
        exc_take = 1'b0;
        exc_code = CAUSE_ILLEGAL;
        exc_tval = '0;
        xret     = 1'b0;
        mret_sel = 1'b0;
        if (ex_valid) begin
            case (ex_event)
                EV_NONE: ;
                EV_ECALL: begin
                    exc_take = 1'b1;
                    case (priv)
                        PRIV_U:  exc_code = CAUSE_ECALL_U;
                        PRIV_S:  exc_code = CAUSE_ECALL_S;
                        default: exc_code = CAUSE_ECALL_M;
                    endcase
                end
                EV_ILLEGAL: begin
                    exc_take = 1'b1;
                    exc_tval = ex_tval;
                end
                EV_SRET: begin
                    if (priv == PRIV_U) begin
                        exc_take = 1'b1;
                        exc_tval = ex_tval;
                    end else begin
                        xret = 1'b1;
                    end
                end
                EV_MRET: begin
                    if (priv != PRIV_M) begin
                        exc_take = 1'b1;
                        exc_tval = ex_tval;
                    end else begin
                        xret     = 1'b1;
                        mret_sel = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        take    = irq_take || exc_take || xret;
        is_xret = !irq_take && xret;
        is_mret = !irq_take && mret_sel;
        if (irq_take) begin
            cause  = irq_cause;
            tval   = '0;
            target = PRIV_M;
        end else if (xret) begin
            cause  = '0;
            tval   = '0;
            target = mret_sel ? PRIV_M : PRIV_S;
        end else begin
            cause  = XLEN'(exc_code);
            tval   = exc_tval;
            target = (medeleg[exc_code] && (priv != PRIV_M)) ? PRIV_S : PRIV_M;
        end
    end

endmodule

// File: rtl/priv_trap_ctrl.sv
// Privilege-mode register and trap/xRET sequencer: snapshots an accepted
// event, emits its CSR writes one per cycle, then pulses a PC redirect.
module priv_trap_ctrl
    import riscv_priv_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int NUM_IRQ   = 4,
    parameter int HAS_UMODE = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               ex_valid,
    input  logic [2:0]         ex_event,
    input  logic [XLEN-1:0]    ex_pc,
    input  logic [XLEN-1:0]    ex_tval,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] mie,
    input  logic [XLEN-1:0]    mstatus,
    input  logic [XLEN-1:0]    medeleg,
    input  logic [XLEN-1:0]    mtvec,
    input  logic [XLEN-1:0]    stvec,
    input  logic [XLEN-1:0]    mepc,
    input  logic [XLEN-1:0]    sepc,
    output logic               csr_we,
    output logic [11:0]        csr_waddr,
    output logic [XLEN-1:0]    csr_wdata,
    output logic               flush,
    output logic               busy,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,
    output logic [1:0]         priv,
    output logic [2:0]         state_dbg
);

    trap_state_e     state, next_state;
    logic            sel_take, sel_is_xret, sel_is_mret;
    logic [XLEN-1:0] sel_cause, sel_tval;
    logic [1:0]      sel_target;
    logic            take_now;
    logic [XLEN-1:0] status_new, redir_new;
    logic [1:0]      priv_new;

    logic [XLEN-1:0] snap_pc, snap_cause, snap_tval, snap_status, snap_redir;
    logic [1:0]      snap_priv;
    logic            snap_tgt_s;

    trap_cause_sel #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) u_sel (
        .ex_valid    (ex_valid),
        .ex_event    (ex_event),
        .ex_tval     (ex_tval),
        .irq         (irq),
        .mie         (mie),
        .mstatus_mie (mstatus[MIE_BIT]),
        .priv        (priv),
        .medeleg     (medeleg),
        .take        (sel_take),
        .is_xret     (sel_is_xret),
        .is_mret     (sel_is_mret),
        .cause       (sel_cause),
        .tval        (sel_tval),
        .target      (sel_target)
    );

    // Handshake: an event on ex_valid/irq is consumed only in the cycle busy
    // is low; while busy is high the commit stage must hold and inputs are ignored.
    assign take_now  = (state == ST_IDLE) && sel_take;
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    // Resulting status word and privilege, computed at accept and then frozen.
    always_comb begin
        status_new = mstatus;
        redir_new  = '0;
        priv_new   = PRIV_M;
        if (sel_is_xret) begin
            if (sel_is_mret) begin
                status_new[MIE_BIT]        = mstatus[MPIE_BIT];
                status_new[MPIE_BIT]       = 1'b1;
                status_new[MPP_HI:MPP_LO]  = (HAS_UMODE != 0) ? PRIV_U : PRIV_S;
                priv_new                   = mstatus[MPP_HI:MPP_LO];
                redir_new                  = mepc;
            end else begin
                status_new[SIE_BIT]  = mstatus[SPIE_BIT];
                status_new[SPIE_BIT] = 1'b1;
                status_new[SPP_BIT]  = 1'b0;
                priv_new             = {1'b0, mstatus[SPP_BIT]};
                redir_new            = sepc;
            end
        end else if (sel_target == PRIV_S) begin
            status_new[SPP_BIT]  = priv[0];
            status_new[SPIE_BIT] = mstatus[SIE_BIT];
            status_new[SIE_BIT]  = 1'b0;
            priv_new             = PRIV_S;
            redir_new            = {stvec[XLEN-1:2], 2'b00};
        end else begin
            status_new[MPP_HI:MPP_LO] = priv;
            status_new[MPIE_BIT]      = mstatus[MIE_BIT];
            status_new[MIE_BIT]       = 1'b0;
            priv_new                  = PRIV_M;
            redir_new                 = {mtvec[XLEN-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (take_now) next_state = sel_is_xret ? ST_W_STATUS : ST_W_EPC;
            ST_W_EPC:    next_state = ST_W_CAUSE;
            ST_W_CAUSE:  next_state = ST_W_TVAL;
            ST_W_TVAL:   next_state = ST_W_STATUS;
            ST_W_STATUS: next_state = ST_REDIR;
            ST_REDIR:    next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snap_pc     <= '0;
            snap_cause  <= '0;
            snap_tval   <= '0;
            snap_status <= '0;
            snap_redir  <= '0;
            snap_priv   <= PRIV_M;
            snap_tgt_s  <= 1'b0;
            flush       <= 1'b0;
            priv        <= PRIV_M;
        end else begin
            flush <= take_now;
            if (take_now) begin
                snap_pc     <= ex_pc;
                snap_cause  <= sel_cause;
                snap_tval   <= sel_tval;
                snap_status <= status_new;
                snap_redir  <= redir_new;
                snap_priv   <= priv_new;
                snap_tgt_s  <= (sel_target == PRIV_S);
            end
            if (state == ST_W_STATUS) priv <= snap_priv;
        end
    end

    always_comb begin
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            ST_W_EPC: begin
                csr_we    = 1'b1;
                csr_waddr = snap_tgt_s ? CSR_SEPC : CSR_MEPC;
                csr_wdata = snap_pc;
            end
            ST_W_CAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = snap_tgt_s ? CSR_SCAUSE : CSR_MCAUSE;
                csr_wdata = snap_cause;
            end
            ST_W_TVAL: begin
                csr_we    = 1'b1;
                csr_waddr = snap_tgt_s ? CSR_STVAL : CSR_MTVAL;
                csr_wdata = snap_tval;
            end
            ST_W_STATUS: begin
                csr_we    = 1'b1;
                csr_waddr = snap_tgt_s ? CSR_SSTATUS : CSR_MSTATUS;
                csr_wdata = snap_status;
            end
            ST_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = snap_redir;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_priv_trap_ctrl.sv
// Directed bench for priv_trap_ctrl: expected CSR writes and redirects, each
// tagged with the cycle it must appear in, are queued and checked by a monitor.
module tb_priv_trap_ctrl;

    localparam int W = 94;  // {cycle[15:0], kind[1:0], addr[11:0], data[63:0]}
    localparam logic [2:0] EV_ECALL = 3'd1, EV_ILLEGAL = 3'd2, EV_SRET = 3'd3, EV_MRET = 3'd4;

    logic        clk, rstn;
    logic        ex_valid;
    logic [2:0]  ex_event;
    logic [63:0] ex_pc, ex_tval;
    logic [3:0]  irq, mie;
    logic [63:0] mstatus, medeleg, mtvec, stvec, mepc, sepc;
    logic        csr_we, flush, busy, redirect_valid;
    logic [11:0] csr_waddr;
    logic [63:0] csr_wdata, redirect_pc;
    logic [1:0]  priv;
    logic [2:0]  state_dbg;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int a_cyc    = 0;

    priv_trap_ctrl #(.XLEN(64), .NUM_IRQ(4), .HAS_UMODE(1)) dut (
        .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .ex_event(ex_event),
        .ex_pc(ex_pc), .ex_tval(ex_tval), .irq(irq), .mie(mie),
        .mstatus(mstatus), .medeleg(medeleg), .mtvec(mtvec), .stvec(stvec),
        .mepc(mepc), .sepc(sepc), .csr_we(csr_we), .csr_waddr(csr_waddr),
        .csr_wdata(csr_wdata), .flush(flush), .busy(busy),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .priv(priv), .state_dbg(state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Scoreboard
    task automatic out_check(input string name, input logic [W-1:0] got);
        logic [W-1:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: got unexpected %h, expected nothing", name, got);
        end else begin
            e = exp_q.pop_front();
            if (got === e) n_pass++;
            else $display("FAIL %s: got %h, expected %h", name, got, e);
        end
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (csr_we)
                out_check("csr_write", {cyc[15:0], 2'd1, csr_waddr, csr_wdata});
            if (redirect_valid)
                out_check("redirect", {cyc[15:0], 2'd2, 12'h000, redirect_pc});
        end
    end

    task automatic expect_out(input int off, input logic [1:0] kind,
                              input logic [11:0] addr, input logic [63:0] data);
        logic [15:0] c;
        c = 16'(a_cyc + off);
        exp_q.push_back({c, kind, addr, data});
    endtask

    task automatic exp_trap(input bit tgt_s, input logic [63:0] epc, input logic [63:0] cause,
                            input logic [63:0] tval, input logic [63:0] status,
                            input logic [63:0] redir);
        expect_out(1, 2'd1, tgt_s ? 12'h141 : 12'h341, epc);
        expect_out(2, 2'd1, tgt_s ? 12'h142 : 12'h342, cause);
        expect_out(3, 2'd1, tgt_s ? 12'h143 : 12'h343, tval);
        expect_out(4, 2'd1, tgt_s ? 12'h100 : 12'h300, status);
        expect_out(5, 2'd2, 12'h000, redir);
    endtask

    task automatic exp_xret(input bit tgt_s, input logic [63:0] status, input logic [63:0] redir);
        expect_out(1, 2'd1, tgt_s ? 12'h100 : 12'h300, status);
        expect_out(2, 2'd2, 12'h000, redir);
    endtask

    // Drivers
    task automatic set_csr(input logic [63:0] st, input logic [63:0] deleg, input logic [63:0] mt,
                           input logic [63:0] stv, input logic [63:0] me, input logic [63:0] se);
        mstatus = st; medeleg = deleg; mtvec = mt; stvec = stv; mepc = me; sepc = se;
    endtask

    task automatic issue(input logic [2:0] ev, input logic [63:0] pc, input logic [63:0] tv,
                         input logic [3:0] irq_v);
        @(posedge clk); #1;
        ex_valid = (ev != 3'd0);
        ex_event = ev;
        ex_pc    = pc;
        ex_tval  = tv;
        irq      = irq_v;
        a_cyc    = cyc;
    endtask

    // Scrambles CSR inputs and fires ignored events mid-sequence, then checks timing.
    task automatic finish_ev(input bit trap, input logic [1:0] exp_priv, input string name);
        @(posedge clk); #1;  // A+1
        ex_valid = 1'b0; ex_event = 3'd0; irq = 4'h0;
        check({name, "_flush_a1"}, 64'(flush), 64'd1);
        check({name, "_busy_a1"}, 64'(busy), 64'd1);
        set_csr({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        @(posedge clk); #1;  // A+2
        check({name, "_flush_a2"}, 64'(flush), 64'd0);
        ex_valid = 1'b1; ex_event = EV_ILLEGAL; ex_tval = {$urandom, $urandom};
        irq = 4'hf; mie = 4'hf;
        @(posedge clk); #1;  // A+3
        ex_valid = 1'b0; ex_event = 3'd0; irq = 4'h0;
        if (trap) begin
            repeat (2) begin @(posedge clk); #1; end  // A+5
            check({name, "_busy_a5"}, 64'(busy), 64'd1);
            @(posedge clk); #1;  // A+6
            check({name, "_busy_a6"}, 64'(busy), 64'd0);
        end else begin
            check({name, "_busy_a3"}, 64'(busy), 64'd0);
        end
        check({name, "_priv"}, 64'(priv), 64'(exp_priv));
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rstn = 1'b0; ex_valid = 1'b0; ex_event = 3'd0; ex_pc = '0; ex_tval = '0;
        irq = 4'h0; mie = 4'h0;
        set_csr(64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
        #12;
        check("rst_csr_we", 64'(csr_we), 64'd0);
        check("rst_flush", 64'(flush), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        check("rst_csr_waddr", 64'(csr_waddr), 64'd0);
        check("rst_csr_wdata", csr_wdata, 64'd0);
        check("rst_redirect_pc", redirect_pc, 64'd0);
        check("rst_priv", 64'(priv), 64'd3);
        #8 rstn = 1'b1;

        // ecall from M, MIE=1: MPP=3, MPIE=1, MIE=0
        set_csr(64'h8, 64'h0, 64'h80001003, 64'h0, 64'h0, 64'h0); mie = 4'h0;
        issue(EV_ECALL, 64'h80000010, 64'h0, 4'h0);
        exp_trap(1'b0, 64'h80000010, 64'd11, 64'h0, 64'h1880, 64'h80001000);
        finish_ev(1'b1, 2'b11, "ecall_m");

        // mret with MPP=U, MPIE=1 drops to U
        set_csr(64'h80, 64'h0, 64'h0, 64'h0, 64'h1000, 64'h0); mie = 4'h0;
        issue(EV_MRET, 64'h500, 64'h0, 4'h0);
        exp_xret(1'b0, 64'h88, 64'h1000);
        finish_ev(1'b0, 2'b00, "mret_to_u");

        // delegated ecall from U to S
        set_csr(64'h2, 64'h100, 64'h0, 64'h2000, 64'h0, 64'h0); mie = 4'h0;
        issue(EV_ECALL, 64'h3000, 64'h0, 4'h0);
        exp_trap(1'b1, 64'h3000, 64'd8, 64'h0, 64'h20, 64'h2000);
        finish_ev(1'b1, 2'b01, "ecall_u_deleg");

        // sret from S with SPP=0, SPIE=1
        set_csr(64'h20, 64'h0, 64'h0, 64'h0, 64'h0, 64'h4000); mie = 4'h0;
        issue(EV_SRET, 64'h600, 64'h0, 4'h0);
        exp_xret(1'b1, 64'h22, 64'h4000);
        finish_ev(1'b0, 2'b00, "sret_to_u");

        // interrupt on line 1 beats simultaneous ecall in U
        set_csr(64'h2, 64'h100, 64'h80001003, 64'h2000, 64'h0, 64'h0); mie = 4'b1110;
        issue(EV_ECALL, 64'h5000, 64'hdead, 4'b0110);
        exp_trap(1'b0, 64'h5000, 64'h8000000000000001, 64'h0, 64'h2, 64'h80001000);
        finish_ev(1'b1, 2'b11, "irq_wins");

        // mret with MPP=S
        set_csr(64'h800, 64'h0, 64'h0, 64'h0, 64'h6000, 64'h0); mie = 4'h0;
        issue(EV_MRET, 64'h700, 64'h0, 4'h0);
        exp_xret(1'b0, 64'h80, 64'h6000);
        finish_ev(1'b0, 2'b01, "mret_to_s");

        // mret in S becomes an illegal-instruction trap to M
        set_csr(64'h0, 64'h100, 64'h80001003, 64'h2000, 64'h0, 64'h0); mie = 4'h0;
        issue(EV_MRET, 64'h7000, 64'h30200073, 4'h0);
        exp_trap(1'b0, 64'h7000, 64'd2, 64'h30200073, 64'h800, 64'h80001000);
        finish_ev(1'b1, 2'b11, "mret_illegal");

        // interrupt masked in M with MIE=0: the ecall is taken instead
        set_csr(64'h0, 64'h0, 64'h80001003, 64'h0, 64'h0, 64'h0); mie = 4'b0001;
        issue(EV_ECALL, 64'h9000, 64'h0, 4'b0001);
        exp_trap(1'b0, 64'h9000, 64'd11, 64'h0, 64'h1800, 64'h80001000);
        finish_ev(1'b1, 2'b11, "irq_masked_m");

        // reset in the middle of a trap sequence
        set_csr(64'h0, 64'h0, 64'h80001003, 64'h0, 64'h0, 64'h0); mie = 4'h0;
        issue(EV_ECALL, 64'h8000, 64'h0, 4'h0);
        expect_out(1, 2'd1, 12'h341, 64'h8000);
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_event = 3'd0;
        @(posedge clk); #1;
        rstn = 1'b0;
        #2;
        check("abort_priv", 64'(priv), 64'd3);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_csr_we", 64'(csr_we), 64'd0);
        check("abort_redirect", 64'(redirect_valid), 64'd0);
        @(negedge clk) rstn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("abort_post_busy", 64'(busy), 64'd0);
        check("abort_post_priv", 64'(priv), 64'd3);
        check("abort_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
